axi_burst_writer: RTL and testbench

AXI_BURST_WRITER -- requirements
Module: axi_burst_writer

---
 rtl/axi_burst_writer.sv | 177 +++++++++++++++++
 tb/tb_axi_burst_writer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_writer.sv
// axi_burst_writer: turns a (address, byte length) write request plus a data
// stream into one or more AXI4 INCR write bursts, one burst outstanding at a
// time, and reports a single OK/error status per request.
// Optional feature: define AXI_BURST_WRITER_4K_SPLIT_EN to also split bursts
// at 4 KB address boundaries.
module axi_burst_writer #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 16,
    parameter int ID_W      = 4,
    parameter int AXI_ID    = 0,
    parameter int MAX_BURST = 16
) (
    input  logic                clk,
    input  logic                rst,
    // write request
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [LEN_W-1:0]    req_len,
    input  logic                req_vld,
    output logic                req_rdy,
    // completion response
    output logic                resp_status,
    output logic                resp_vld,
    input  logic                resp_rdy,
    // data stream
    input  logic [DATA_W-1:0]   s_tdata,
    input  logic [DATA_W/8-1:0] s_tkeep,
    input  logic                s_tlast,
    input  logic                s_tvalid,
    output logic                s_tready,
    // AXI write address
    output logic [ID_W-1:0]     awid,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic                awvalid,
    input  logic                awready,
    // AXI write data
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    // AXI write response
    input  logic [1:0]          bresp,
    input  logic [ID_W-1:0]     bid,
    input  logic                bvalid,
    output logic                bready
);

    localparam int BYTES = DATA_W / 8;
    localparam int SIZE  = $clog2(BYTES);
    // Common width for comparing beat counts from different sources.
    localparam int CW    = (LEN_W + 1 > 13) ? LEN_W + 1 : 13;

    localparam logic [LEN_W:0]    BYTES_M1   = (LEN_W + 1)'(BYTES - 1);
    localparam logic [LEN_W-1:0]  BYTES_LEN  = LEN_W'(BYTES);
    localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_RESP
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [ADDR_W-1:0] addr;         // address of the next beat to write
    logic [LEN_W-1:0]  remaining;    // bytes still to be written for this request
    logic              err;          // sticky error over all bursts of the request
    logic [8:0]        beat_cnt;     // beats left in the current burst
    logic [8:0]        burst_beats;  // size of the burst about to be issued

    logic              w_hs;
    logic              final_beat;
    logic [LEN_W-1:0]  rem_low;
    logic [LEN_W:0]    rem_beats;
    logic [CW-1:0]     cand;

    // Sideband stream fields carry no meaning here; framing is by byte count.
    logic              unused_inputs;
    assign unused_inputs = ^{s_tkeep, s_tlast, bid};

    assign w_hs       = (state == S_W) && s_tvalid && wready;
    assign final_beat = (remaining <= BYTES_LEN);
    assign rem_low    = remaining % BYTES_LEN;

`ifdef AXI_BURST_WRITER_4K_SPLIT_EN
    logic [12:0] beats_4k;
    assign beats_4k = (13'h1000 - {1'b0, addr[11:0]}) >> SIZE;
`endif

    // Burst size: remaining beats, capped by MAX_BURST (and the 4 KB boundary when enabled).
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        rem_beats = ({1'b0, remaining} + BYTES_M1) >> SIZE;
        cand      = CW'(rem_beats);
        if (cand > CW'(MAX_BURST)) cand = CW'(MAX_BURST);
`ifdef AXI_BURST_WRITER_4K_SPLIT_EN
        if (cand > CW'(beats_4k)) cand = CW'(beats_4k);
`endif
        burst_beats = 9'(cand);
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (req_vld) state_nxt = (req_len == '0) ? S_RESP : S_AW;
            S_AW:   if (awready) state_nxt = S_W;
            S_W:    if (w_hs && wlast) state_nxt = S_B;
            S_B:    if (bvalid) state_nxt = (remaining != '0) ? S_AW : S_RESP;
            S_RESP: if (resp_rdy) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request bookkeeping: address, byte count, beat counter and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr      <= '0;
            remaining <= '0;
            err       <= 1'b0;
            beat_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: if (req_vld) begin
                    addr      <= req_addr & ALIGN_MASK;
                    remaining <= req_len;
                    err       <= 1'b0;
                end
                S_AW: if (awready) beat_cnt <= burst_beats;
                S_W: if (w_hs) begin
                    addr      <= addr + ADDR_STEP;
                    remaining <= final_beat ? '0 : remaining - BYTES_LEN;
                    beat_cnt  <= beat_cnt - 9'd1;
                end
                S_B: if (bvalid) err <= err | (bresp != 2'b00);
                default: ;
            endcase
        end
    end

    // Output decode: handshake strobes per state plus the data pass-through.
    always_comb begin
        req_rdy     = (state == S_IDLE);
        awvalid     = (state == S_AW);
        wvalid      = (state == S_W) && s_tvalid;
        s_tready    = (state == S_W) && wready;
        bready      = (state == S_B);
        resp_vld    = (state == S_RESP);
        resp_status = err;
        awid        = ID_W'(AXI_ID);
        awaddr      = addr;
        awlen       = 8'(burst_beats - 9'd1);
        awsize      = 3'(SIZE);
        awburst     = 2'b01;
        wdata       = s_tdata;
        wlast       = (beat_cnt == 9'd1);
        for (int i = 0; i < BYTES; i++) begin
            wstrb[i] = !final_beat || (rem_low == '0) || (LEN_W'(i) < rem_low);
        end
    end

endmodule

// File: tb/tb_axi_burst_writer.sv
// Self-checking bench for axi_burst_writer (default parameters, DATA_W=32,
// MAX_BURST=16). Table of request vectors with expected AXI traffic, plus
// hand-written sequences for reset state and reset in mid-transfer.
module tb_axi_burst_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req_addr;
    logic [15:0] req_len;
    logic        req_vld;
    logic        req_rdy;
    logic        resp_status;
    logic        resp_vld;
    logic        resp_rdy;
    logic [31:0] s_tdata;
    logic [3:0]  s_tkeep;
    logic        s_tlast;
    logic        s_tvalid;
    logic        s_tready;
    logic [3:0]  awid;
    logic [15:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    logic        bvalid;
    logic        bready;

    axi_burst_writer dut (
        .clk(clk), .rst(rst),
        .req_addr(req_addr), .req_len(req_len), .req_vld(req_vld), .req_rdy(req_rdy),
        .resp_status(resp_status), .resp_vld(resp_vld), .resp_rdy(resp_rdy),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .s_tvalid(s_tvalid), .s_tready(s_tready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bid(bid), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [15:0] len;
        int          err_burst;   // index of burst answered with SLVERR, -1 for none
        bit          stall;       // throttle the AXI slave and stream source
        int          hold;        // cycles resp_rdy stays low once resp_vld rises
        int          n_aw;
        int          aw0_addr;
        int          aw0_len;
        int          aw1_addr;
        int          aw1_len;
        int          n_w;
        int          last_strb;
        int          status;
    } vec_t;

    // Observations from the most recent request.
    int r_n_aw, r_n_w, r_n_last, r_status, r_last_strb, r_resp_cycles, r_resp_lat;
    int r_data_bad, r_strb_bad, r_rdy_bad, r_order_bad, r_attr_bad, r_timeout;
    int r_aw_addr[4];
    int r_aw_len[4];

    task automatic run_req(input vec_t v);
        int  cyc = 0;
        int  acc_cyc = 0;
        int  bcount = 0;
        int  prev_strb = 'hF;
        bit  accepted = 0;
        bit  done = 0;
        r_n_aw = 0; r_n_w = 0; r_n_last = 0; r_status = -1; r_last_strb = 0;
        r_resp_cycles = 0; r_resp_lat = -1;
        r_data_bad = 0; r_strb_bad = 0; r_rdy_bad = 0; r_order_bad = 0; r_attr_bad = 0;
        for (int i = 0; i < 4; i++) begin
            r_aw_addr[i] = -1;
            r_aw_len[i]  = -1;
        end
        while (!done && cyc < 800) begin
            @(negedge clk);
            req_vld  = !accepted;
            req_addr = v.addr;
            req_len  = v.len;
            awready  = v.stall ? (cyc % 2 == 1) : 1'b1;
            wready   = v.stall ? (cyc % 3 != 0) : 1'b1;
            s_tvalid = v.stall ? (cyc % 5 != 2) : 1'b1;
            s_tdata  = $urandom;
            s_tkeep  = 4'($urandom);
            s_tlast  = 1'($urandom);
            bvalid   = v.stall ? (cyc % 2 == 0) : 1'b1;
            bresp    = (bcount == v.err_burst) ? 2'b10 : 2'b00;
            bid      = 4'($urandom);
            resp_rdy = (r_resp_cycles >= v.hold);
            #1;
            if (accepted && req_rdy) r_rdy_bad++;
            if (req_vld && req_rdy) begin
                accepted = 1;
                acc_cyc  = cyc;
            end
            if (awvalid && awready) begin
                if (r_n_aw < 4) begin
                    r_aw_addr[r_n_aw] = int'(awaddr);
                    r_aw_len[r_n_aw]  = int'(awlen);
                end
                if (awsize != 3'd2 || awburst != 2'b01 || awid != 4'd0) r_attr_bad++;
                r_n_aw++;
            end
            if (wvalid && r_n_aw == r_n_last) r_order_bad++;
            if (wvalid && wready) begin
                if (wdata != s_tdata) r_data_bad++;
                if (r_n_w > 0 && prev_strb != 'hF) r_strb_bad++;
                prev_strb   = int'(wstrb);
                r_last_strb = int'(wstrb);
                if (wlast) r_n_last++;
                r_n_w++;
            end
            if (bvalid && bready) bcount++;
            if (resp_vld) begin
                if (r_resp_cycles == 0) r_resp_lat = cyc - acc_cyc;
                r_resp_cycles++;
                r_status = int'(resp_status);
                if (resp_rdy) done = 1;
            end
            cyc++;
        end
        r_timeout = done ? 0 : 1;
    endtask

    task automatic check_req(input string tag, input vec_t v);
        check({tag, " timeout"}, r_timeout, 0);
        check({tag, " aw_count"}, r_n_aw, v.n_aw);
        if (v.n_aw > 0) begin
            check({tag, " aw0_addr"}, r_aw_addr[0], v.aw0_addr);
            check({tag, " aw0_len"}, r_aw_len[0], v.aw0_len);
        end
        if (v.n_aw > 1) begin
            check({tag, " aw1_addr"}, r_aw_addr[1], v.aw1_addr);
            check({tag, " aw1_len"}, r_aw_len[1], v.aw1_len);
        end
        check({tag, " w_beats"}, r_n_w, v.n_w);
        check({tag, " wlast_count"}, r_n_last, v.n_aw);
        if (v.n_w > 0) check({tag, " last_wstrb"}, r_last_strb, v.last_strb);
        check({tag, " inner_wstrb_bad"}, r_strb_bad, 0);
        check({tag, " wdata_bad"}, r_data_bad, 0);
        check({tag, " aw_attr_bad"}, r_attr_bad, 0);
        check({tag, " w_before_aw"}, r_order_bad, 0);
        check({tag, " req_rdy_busy"}, r_rdy_bad, 0);
        check({tag, " resp_status"}, r_status, v.status);
        check({tag, " resp_cycles"}, r_resp_cycles, v.hold + 1);
        if (v.len == 0) check({tag, " resp_latency_le2"}, int'(r_resp_lat <= 2), 1);
    endtask

    vec_t vecs[7];
    int   bad;

    initial begin
        // addr, len, err_burst, stall, hold, n_aw, aw0 addr/len, aw1 addr/len, n_w, last strb, status
        vecs[0] = '{16'h0000, 16'd64,  -1, 0, 0, 1, 'h0000, 15, 0, 0, 16, 'hF, 0};
`ifdef AXI_BURST_WRITER_4K_SPLIT_EN
        vecs[1] = '{16'h0FF8, 16'd16,  -1, 0, 0, 2, 'h0FF8, 1, 'h1000, 1, 4, 'hF, 0};
`else
        vecs[1] = '{16'h0FF8, 16'd16,  -1, 0, 0, 1, 'h0FF8, 3, 0, 0, 4, 'hF, 0};
`endif
        vecs[2] = '{16'h0100, 16'd7,   -1, 0, 0, 1, 'h0100, 1, 0, 0, 2, 'h7, 0};
        vecs[3] = '{16'h0200, 16'd0,   -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[4] = '{16'h2000, 16'd128,  0, 0, 3, 2, 'h2000, 15, 'h2040, 15, 32, 'hF, 1};
        vecs[5] = '{16'h0103, 16'd5,   -1, 1, 0, 1, 'h0100, 1, 0, 0, 2, 'h1, 0};
        vecs[6] = '{16'h3000, 16'd70,  -1, 1, 2, 2, 'h3000, 15, 'h3040, 1, 18, 'h3, 0};

        rst = 1'b1; req_addr = '0; req_len = '0; req_vld = 1'b0; resp_rdy = 1'b0;
        s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tvalid = 1'b1;
        awready = 1'b1; wready = 1'b1; bresp = 2'b00; bid = '0; bvalid = 1'b1;

        // Reset state: outputs quiet even with all slave/stream inputs asserted.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset req_rdy", int'(req_rdy), 1);
        check("reset awvalid", int'(awvalid), 0);
        check("reset wvalid", int'(wvalid), 0);
        check("reset s_tready", int'(s_tready), 0);
        check("reset bready", int'(bready), 0);
        check("reset resp_vld", int'(resp_vld), 0);

        for (int i = 0; i < 7; i++) begin
            run_req(vecs[i]);
            check_req($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset asserted while the third W beat of a 16-beat burst is on the bus.
        begin
            int  nb = 0;
            int  cyc = 0;
            bit  accepted = 0;
            while (nb < 3 && cyc < 100) begin
                @(negedge clk);
                req_vld = !accepted; req_addr = 16'h0400; req_len = 16'd64;
                awready = 1'b1; wready = 1'b1; s_tvalid = 1'b1; bvalid = 1'b1;
                bresp = 2'b00; resp_rdy = 1'b1; s_tdata = $urandom;
                #1;
                if (req_vld && req_rdy) accepted = 1;
                if (wvalid && wready) nb++;
                if (nb == 3) rst = 1'b1;
                cyc++;
            end
            check("midreset reached beat3", nb, 3);
            req_vld = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            #1;
            check("midreset awvalid", int'(awvalid), 0);
            check("midreset wvalid", int'(wvalid), 0);
            check("midreset resp_vld", int'(resp_vld), 0);
            check("midreset req_rdy", int'(req_rdy), 1);
            bad = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                #1;
                if (resp_vld || awvalid || wvalid || bready || !req_rdy) bad++;
            end
            check("midreset stays idle", bad, 0);
        end
        run_req(vecs[0]);
        check_req("after_reset", vecs[0]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
